// File: rtl/a7_link_pkg.sv
// a7_link_pkg: shared constants, FSM states and command-frame builder for the
// single-wire byte link to the Spartan6/Artix7 busfsm.
package a7_link_pkg;
    localparam logic [7:0] OP_RD          = 8'h01;
    localparam logic [7:0] OP_WR          = 8'h02;
    localparam logic [7:0] STATUS_TIMEOUT = 8'hFF;
    localparam int         FRAME_BITS     = 10;
    localparam int         RSP_BYTES      = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TX_FRAME,
        S_TX_GAP,
        S_RX_WAIT,
        S_DONE
    } state_e;

    // Returns {last, byte} for command byte idx of a read (3 bytes) or write (5 bytes).
    function automatic logic [8:0] cmd_frame(input logic wr, input logic [15:0] addr,
                                             input logic [15:0] data, input logic [2:0] idx);
        logic [7:0] b;
        b = (idx == 3'd0) ? (wr ? OP_WR : OP_RD) :
            (idx == 3'd1) ? addr[15:8] :
            (idx == 3'd2) ? addr[7:0] :
            (idx == 3'd3) ? data[15:8] : data[7:0];
        return {idx == (wr ? 3'd4 : 3'd2), b};
    endfunction
endpackage

// File: rtl/a7_frame_rx.sv
// a7_frame_rx: registers the link input, hunts for a start bit and captures the
// following 9 bits (last flag + byte MSB first); valid_o pulses with the final bit.
module a7_frame_rx
    import a7_link_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       serial_i,
    output logic       valid_o,
    output logic       last_o,
    output logic [7:0] byte_o
);
    logic       sin_q;
    logic       busy_q;
    logic [3:0] cnt_q;
    logic [7:0] sh_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sin_q  <= 1'b0;
            busy_q <= 1'b0;
            cnt_q  <= '0;
            sh_q   <= '0;
        end else begin
            sin_q <= serial_i;
            if (!busy_q) begin
                busy_q <= sin_q;
                cnt_q  <= '0;
            end else begin
                sh_q  <= {sh_q[6:0], sin_q};
                cnt_q <= cnt_q + 4'd1;
                if (cnt_q == 4'(FRAME_BITS - 2))
                    busy_q <= 1'b0;
            end
        end
    end

    // The final bit is consumed straight from the input register, so the next
    // start bit may follow with no gap.
    assign valid_o = busy_q && (cnt_q == 4'(FRAME_BITS - 2));
    assign last_o  = sh_q[7];
    assign byte_o  = {sh_q[6:0], sin_q};
endmodule

// File: rtl/a7_bus_master.sv
// a7_bus_master: serialises one 16-bit bus read/write into framed bytes on the
// single-wire link and assembles the reply into read data and status.
module a7_bus_master
    import a7_link_pkg::*;
#(
    parameter int GAP     = 2,
    parameter int TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wrdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rddata,
    output logic [7:0]  rsp_status,
    output logic        rsp_timeout,
    output logic        serial_out,
    input  logic        serial_in,
    output logic [15:0] frames_sent,
    output logic [15:0] frames_rcvd
);
    state_e      state_q;
    logic        req_ready_q, serial_out_q, rsp_valid_q, rsp_timeout_q, wr_q;
    logic [8:0]  sh_q;
    logic [9:0]  cnt_q;
    logic [2:0]  idx_q;
    logic [15:0] addr_q, data_q, rsp_rddata_q, frames_sent_q, frames_rcvd_q;
    logic [7:0]  rsp_status_q;
    logic [8*(RSP_BYTES-1)-1:0] rx_q;
    logic [8*RSP_BYTES-1:0]     rx_d;
    logic        rx_valid, rx_last, cur_last;
    logic [7:0]  rx_byte;
    logic [8:0]  nxt_frame;

    a7_frame_rx u_rx (
        .clk      (clk),
        .rst      (rst),
        .serial_i (serial_in),
        .valid_o  (rx_valid),
        .last_o   (rx_last),
        .byte_o   (rx_byte)
    );

    // Reply window keeps the newest RSP_BYTES bytes: {hi, lo, status}.
    assign rx_d      = {rx_q, rx_byte};
    assign cur_last  = idx_q == (wr_q ? 3'd4 : 3'd2);
    assign nxt_frame = cmd_frame(wr_q, addr_q, data_q, idx_q + 3'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            req_ready_q   <= 1'b1;
            serial_out_q  <= 1'b0;
            sh_q          <= '0;
            cnt_q         <= '0;
            idx_q         <= '0;
            wr_q          <= 1'b0;
            addr_q        <= '0;
            data_q        <= '0;
            rx_q          <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rddata_q  <= '0;
            rsp_status_q  <= '0;
            rsp_timeout_q <= 1'b0;
            frames_sent_q <= '0;
            frames_rcvd_q <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            if (rx_valid)
                frames_rcvd_q <= frames_rcvd_q + 16'd1;
            case (state_q)
                S_IDLE: if (req_valid && req_ready_q) begin
                    state_q                <= S_TX_FRAME;
                    req_ready_q            <= 1'b0;
                    wr_q                   <= req_wr;
                    addr_q                 <= req_addr;
                    data_q                 <= req_wrdata;
                    rx_q                   <= '0;
                    idx_q                  <= '0;
                    cnt_q                  <= '0;
                    {serial_out_q, sh_q}   <= {1'b1, cmd_frame(req_wr, req_addr, req_wrdata, 3'd0)};
                    frames_sent_q          <= frames_sent_q + 16'd1;
                end
                S_TX_FRAME: begin
                    {serial_out_q, sh_q} <= {sh_q, 1'b0};
                    cnt_q                <= cnt_q + 10'd1;
                    if (cnt_q == 10'(FRAME_BITS - 2)) begin
                        state_q <= S_TX_GAP;
                        cnt_q   <= '0;
                    end
                end
                S_TX_GAP: if (cnt_q == 10'(GAP)) begin
                    cnt_q <= '0;
                    if (cur_last) begin
                        state_q      <= S_RX_WAIT;
                        serial_out_q <= 1'b0;
                    end else begin
                        state_q              <= S_TX_FRAME;
                        idx_q                <= idx_q + 3'd1;
                        {serial_out_q, sh_q} <= {1'b1, nxt_frame};
                        frames_sent_q        <= frames_sent_q + 16'd1;
                    end
                end else begin
                    serial_out_q <= 1'b0;
                    cnt_q        <= cnt_q + 10'd1;
                end
                S_RX_WAIT: begin
                    cnt_q <= cnt_q + 10'd1;
                    if (rx_valid)
                        rx_q <= rx_d[8*(RSP_BYTES-1)-1:0];
                    // A completing frame takes priority over a coincident timeout.
                    if (rx_valid && rx_last) begin
                        state_q       <= S_DONE;
                        rsp_valid_q   <= 1'b1;
                        rsp_rddata_q  <= rx_d[23:8];
                        rsp_status_q  <= rx_d[7:0];
                        rsp_timeout_q <= 1'b0;
                    end else if (cnt_q == 10'(TIMEOUT - 1)) begin
                        state_q       <= S_DONE;
                        rsp_valid_q   <= 1'b1;
                        rsp_rddata_q  <= '0;
                        rsp_status_q  <= STATUS_TIMEOUT;
                        rsp_timeout_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q     <= S_IDLE;
                    req_ready_q <= 1'b1;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready   = req_ready_q & ~rst;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rddata  = rsp_rddata_q;
    assign rsp_status  = rsp_status_q;
    assign rsp_timeout = rsp_timeout_q;
    assign serial_out  = serial_out_q;
    assign frames_sent = frames_sent_q;
    assign frames_rcvd = frames_rcvd_q;
endmodule

// File: tb/tb_a7_bus_master.sv
// tb_a7_bus_master: directed sequence with a behavioural far-end busfsm and a
// response scoreboard popped on every rsp_valid pulse.
module tb_a7_bus_master;
    import a7_link_pkg::*;

    logic        clk = 1'b0, rst = 1'b1, req_valid = 1'b0, req_wr = 1'b0, serial_in = 1'b0;
    logic [15:0] req_addr = '0, req_wrdata = '0;
    logic        req_ready, rsp_valid, rsp_timeout, serial_out;
    logic [15:0] rsp_rddata, frames_sent, frames_rcvd;
    logic [7:0]  rsp_status;

    a7_bus_master dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_wrdata(req_wrdata), .rsp_valid(rsp_valid), .rsp_rddata(rsp_rddata),
        .rsp_status(rsp_status), .rsp_timeout(rsp_timeout), .serial_out(serial_out),
        .serial_in(serial_in), .frames_sent(frames_sent), .frames_rcvd(frames_rcvd)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [15:0] rd; logic [7:0] st; logic to; } rsp_t;
    rsp_t        sb[$];
    logic [15:0] mem [0:7];
    int          checks = 0, errors = 0, nrsp = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] rd, input logic [7:0] st, input logic to);
        rsp_t e;
        e.rd = rd; e.st = st; e.to = to;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        rsp_t e;
        if (rsp_valid === 1'b1) begin
            nrsp++;
            check("rsp_expected", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("rsp_rddata", rsp_rddata, e.rd);
                check("rsp_status", rsp_status, e.st);
                check("rsp_timeout", rsp_timeout, e.to);
            end
        end
    end

    task automatic send_req(input logic wr, input logic [15:0] addr, input logic [15:0] data,
                            input logic hold, output int t);
        int n = 0;
        req_wr = wr; req_addr = addr; req_wrdata = data; req_valid = 1'b1;
        while (req_ready !== 1'b1 && n < 2000) begin tick; n++; end
        check("req_ready_wait", req_ready, 1);
        t = cyc;
        tick;
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic read_frame(output logic [8:0] f);
        int n = 0;
        while (serial_out !== 1'b1 && n < 100) begin tick; n++; end
        check("tx_start_bit", serial_out, 1);
        f = '0;
        repeat (9) begin tick; f = {f[7:0], serial_out}; end
        tick;
    endtask

    task automatic send_frame(input logic last, input logic [7:0] b);
        logic [9:0] w;
        w = {1'b1, last, b};
        for (int i = 9; i >= 0; i--) begin serial_in = w[i]; tick; end
        serial_in = 1'b0;
    endtask

    // Far-end busfsm: decode the command, execute it on mem, send the reply.
    task automatic serve(input logic wr, input logic [15:0] addr, input logic [15:0] data);
        logic [7:0] b[$];
        logic [8:0] f;
        for (int i = 0; i < 5; i++) begin
            read_frame(f);
            b.push_back(f[7:0]);
            if (f[8]) break;
        end
        check("cmd_len", b.size(), wr ? 5 : 3);
        if (b.size() >= 3) begin
            check("cmd_op", b[0], wr ? OP_WR : OP_RD);
            check("cmd_addr", {b[1], b[2]}, addr);
        end
        repeat (2) tick;
        if (wr) begin
            if (b.size() == 5) begin
                check("cmd_data", {b[3], b[4]}, data);
                mem[b[2][2:0]] = {b[3], b[4]};
            end
            send_frame(1'b1, 8'h00);
        end else begin
            send_frame(1'b0, mem[addr[2:0]][15:8]);
            send_frame(1'b0, mem[addr[2:0]][7:0]);
            send_frame(1'b1, 8'h00);
        end
    endtask

    task automatic wait_rsp(output int c);
        int n = 0;
        while (rsp_valid !== 1'b1 && n < 3000) begin tick; n++; end
        check("rsp_valid_seen", rsp_valid, 1);
        c = cyc;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t, c, n;
        logic [59:0] cap;
        logic [59:0] exp_tx;
        logic [15:0] r;
        logic [8:0]  f;
        for (int i = 0; i < 8; i++) mem[i] = 16'h0000;
        mem[1] = 16'hBEEF;
        mem[2] = 16'hDEAD;
        exp_tx = {2'b10, 8'h02, 2'b00, 2'b10, 8'h00, 2'b00, 2'b10, 8'h03, 2'b00,
                  2'b10, 8'h12, 2'b00, 2'b11, 8'h34, 2'b00};

        rst = 1'b1;
        repeat (3) tick;
        check("rdy_in_rst", req_ready, 0);
        rst = 1'b0;
        tick;
        check("rst_req_ready", req_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rddata", rsp_rddata, 0);
        check("rst_status", rsp_status, 0);
        check("rst_timeout", rsp_timeout, 0);
        check("rst_serial_out", serial_out, 0);
        check("rst_frames_sent", frames_sent, 0);
        check("rst_frames_rcvd", frames_rcvd, 0);

        // Write 0x0003 <= 0x1234 with bit-exact TX capture, then read it back.
        push(16'h0000, 8'h00, 1'b0);
        send_req(1'b1, 16'h0003, 16'h1234, 1'b0, t);
        for (int i = 0; i < 60; i++) begin cap = {cap[58:0], serial_out}; tick; end
        check("tx_bits_write", cap, exp_tx);
        mem[3] = 16'h1234;
        send_frame(1'b1, 8'h00);
        wait_rsp(c);
        tick;
        push(16'h1234, 8'h00, 1'b0);
        send_req(1'b0, 16'h0003, 16'h0000, 1'b0, t);
        serve(1'b0, 16'h0003, 16'h0000);
        wait_rsp(c);
        check("frames_sent_wr_rd", frames_sent, 8);
        check("frames_rcvd_wr_rd", frames_rcvd, 4);
        tick;

        // Back-to-back reads with req_valid held high.
        push(16'hBEEF, 8'h00, 1'b0);
        send_req(1'b0, 16'h0001, 16'h0000, 1'b1, t);
        serve(1'b0, 16'h0001, 16'h0000);
        req_addr = 16'h0002;
        push(16'hDEAD, 8'h00, 1'b0);
        wait_rsp(c);
        check("b2b_ready_in_done", req_ready, 0);
        tick;
        check("b2b_ready_after_done", req_ready, 1);
        tick;
        check("b2b_start_bit", serial_out, 1);
        check("b2b_ready_low", req_ready, 0);
        req_valid = 1'b0;
        serve(1'b0, 16'h0002, 16'h0000);
        wait_rsp(c);
        check("frames_sent_b2b", frames_sent, 14);
        check("frames_rcvd_b2b", frames_rcvd, 10);
        tick;

        // Timeout with a silent link.
        push(16'h0000, 8'hFF, 1'b1);
        send_req(1'b0, 16'h0001, 16'h0000, 1'b0, t);
        wait_rsp(c);
        check("timeout_cycle", c, t + 36 + 1 + 1023);
        tick;
        check("done_one_cycle", rsp_valid, 0);
        check("timeout_ready", req_ready, 1);
        check("timeout_held", rsp_timeout, 1);
        check("status_held", rsp_status, 8'hFF);

        // Reset at bit 5 of the second command frame.
        send_req(1'b0, 16'h0001, 16'h0000, 1'b0, t);
        while (cyc < t + 18) tick;
        n = nrsp;
        rst = 1'b1;
        tick;
        check("rst_mid_serial_out", serial_out, 0);
        check("rst_mid_ready", req_ready, 0);
        rst = 1'b0;
        tick;
        check("rst_mid_ready_after", req_ready, 1);
        check("rst_mid_frames_sent", frames_sent, 0);
        check("rst_mid_rddata", rsp_rddata, 0);
        repeat (30) tick;
        check("rst_mid_no_rsp", nrsp, n);
        push(16'hBEEF, 8'h00, 1'b0);
        send_req(1'b0, 16'h0001, 16'h0000, 1'b0, t);
        serve(1'b0, 16'h0001, 16'h0000);
        wait_rsp(c);
        tick;

        // Stray last-flagged frame in IDLE, then a four-frame reply.
        n = nrsp;
        r = frames_rcvd;
        send_frame(1'b1, 8'h55);
        repeat (3) tick;
        check("stray_counted", frames_rcvd, r + 16'd1);
        check("stray_no_rsp", nrsp, n);
        push(16'h1234, 8'h00, 1'b0);
        send_req(1'b0, 16'h0005, 16'h0000, 1'b0, t);
        repeat (3) read_frame(f);
        repeat (2) tick;
        send_frame(1'b0, 8'hAA);
        send_frame(1'b0, 8'h12);
        send_frame(1'b0, 8'h34);
        send_frame(1'b1, 8'h00);
        wait_rsp(c);
        check("frames_rcvd_extra", frames_rcvd, r + 16'd5);
        tick;
        check("sb_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
